// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: instruction prefetch queue in front of a 1-cycle-latency
// instruction memory. Keeps at most one read in flight and buffers returned
// words in a small FIFO together with their fetch addresses.
//
// Ports:
//   clk_i            rising-edge clock
//   rst_n            synchronous reset, active HIGH despite the name
//   redirect_i       branch/jump taken: flush queue, reload fetch PC
//   redirect_addr_i  redirect target (low two bits ignored)
//   upg_active_i     UART programmer owns imem: hold fetch, flush, park PC
//   imem_req_o       memory read request (combinational)
//   imem_addr_o      request byte address
//   imem_rdata_i     read data, valid the cycle after a request
//   instr_valid_o    queue head valid
//   instr_ready_i    consumer accepts head
//   instr_o          head instruction
//   pc_o             head instruction address
//   level_o          queued entry count
module ifetch_prefetch #(
    parameter int unsigned        ADDR_W   = 14,
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_n,
    input  logic                        redirect_i,
    input  logic [ADDR_W-1:0]           redirect_addr_i,
    input  logic                        upg_active_i,
    output logic                        imem_req_o,
    output logic [ADDR_W-1:0]           imem_addr_o,
    input  logic [DATA_W-1:0]           imem_rdata_i,
    output logic                        instr_valid_o,
    input  logic                        instr_ready_i,
    output logic [DATA_W-1:0]           instr_o,
    output logic [ADDR_W-1:0]           pc_o,
    output logic [$clog2(DEPTH):0]      level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] flight_addr;
    logic              in_flight;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [LVL_W-1:0]  level;
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];

    logic [LVL_W-1:0]  occupancy;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] redirect_aligned;

    // Request/handshake decode. In-flight slot is reserved so a returning
    // word always has room, which makes overflow impossible.
    always_comb begin
        occupancy        = level + LVL_W'(in_flight);
        imem_req_o       = !rst_n && !upg_active_i && !redirect_i &&
                           (occupancy < LVL_W'(DEPTH));
        imem_addr_o      = fetch_pc;
        instr_valid_o    = (level != '0) && !upg_active_i;
        pop              = instr_valid_o && instr_ready_i;
        push             = in_flight && !rst_n && !upg_active_i && !redirect_i;
        redirect_aligned = redirect_addr_i & ~ADDR_W'(3);
        instr_o          = instr_valid_o ? q_data[rd_ptr] : '0;
        pc_o             = instr_valid_o ? q_pc[rd_ptr]   : '0;
        level_o          = level;
    end

    // Control state: fetch PC, in-flight tracking, queue pointers.
    always_ff @(posedge clk_i) begin
        if (rst_n) begin
            fetch_pc    <= RESET_PC;
            flight_addr <= '0;
            in_flight   <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
        end else if (upg_active_i) begin
            fetch_pc    <= RESET_PC;
            in_flight   <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
        end else if (redirect_i) begin
            // Any handshake this cycle is consumed by the flush itself.
            fetch_pc    <= redirect_aligned;
            in_flight   <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
        end else begin
            in_flight <= imem_req_o;
            if (imem_req_o) begin
                fetch_pc    <= fetch_pc + ADDR_W'(4);
                flight_addr <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Queue storage; contents are masked by level so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_data[wr_ptr] <= imem_rdata_i;
            q_pc[wr_ptr]   <= flight_addr;
        end
    end

endmodule
